hex_digit_scanner: RTL and testbench
====================================

# hex_digit_scanner

Time-multiplexed digit scanner sitting directly upstream of the per-segment 7-segment decoders. Holds a frame of NUM_DIGITS 4-bit hex digits and presents one digit at a time on a 4-bit bus that drives the decoder inputs c3..c0. A one-hot digit enable selects the matching display position. New frames are accepted through a valid/ready handshake and committed only at a frame boundary, so the display never tears mid-scan.

## Interface
- NUM_DIGITS, 4, number of display positions scanned; legal range 2..8
- PRESCALE, 50000, clock cycles per digit slot; legal range >= 2
- clock  input  1  single clock; all state changes on its rising edge
- resetn  input  1  asynchronous, active-low reset
- load_valid  input  1  upstream offers a new frame on load_data
- load_ready  output  1  scanner can accept a frame this cycle
- load_data  input  4*NUM_DIGITS  frame; digit k occupies bits [4k+3:4k]
- digit_out  output  4  current digit to decoder; bit 3 drives c3 … bit 0 drives c0
- digit_en  output  NUM_DIGITS  one-hot enable of the active position, active high
- blank  output  1  high while no position is enabled

## Operation
- State:
  - prescaler count `pcnt` (0..PRESCALE-1)
  - scan index `idx` (0..NUM_DIGITS-1)
  - display register `disp`
  - pending register `pend` with full flag `pfull`
- Reset (async, immediate) values:
  - pcnt=0, idx=0, disp=0, pend=0, pfull=0
  - load_ready=1, digit_out=0, digit_en=1 (position 0 enabled), blank=0
- Prescaler:
  - pcnt increments every cycle.
  - tick asserts when pcnt==PRESCALE-1; pcnt then wraps to 0.
- Scan: on tick, idx advances by 1 and wraps from NUM_DIGITS-1 to 0.
  - Wrap tick = tick with idx==NUM_DIGITS-1.
- Handshake:
  - load_ready = !pfull, driven from a register.
  - Transfer occurs when load_valid && load_ready. Then pend<=load_data, pfull<=1.
  - load_data is ignored when no transfer occurs.
  - Holding load_valid high while load_ready=0 is legal; the offer is not lost or duplicated, it transfers when ready returns.
- Commit:
  - On a wrap tick with pfull=1: disp<=pend and pfull<=0.
  - On a wrap tick with pfull=0: disp unchanged.
- Simultaneous transfer and wrap tick (pfull=0 beforehand): the word goes to pend only and commits at the next wrap tick. It is never bypassed straight into disp.
- Output selection on tick: digit_out <= digit (next idx) of the display contents in effect after the commit. At a committing wrap tick this is pend[3:0].
- digit_en <= one-hot(next idx).

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- digit_out and digit_en change in the cycle after a tick edge. Each non-blanked digit slot lasts exactly PRESCALE cycles.
- A full frame lasts NUM_DIGITS*PRESCALE cycles.
- Handshake:
  - load_ready falls the cycle after a transfer.
  - load_ready rises the cycle after a committing wrap tick.
  - Throughput is at most one frame per scan frame.
- Worst-case frame latency, from transfer to first displayed digit of the new frame: NUM_DIGITS*PRESCALE+1 cycles.
- Reset asserted mid-scan or mid-handshake clears everything, including a pending frame; the dropped frame is not recovered.
- On deassertion, scanning restarts at position 0 with pcnt=0.

## Configuration
- SCANNER_BLANK_EN controls inter-digit blanking.
- Defined: each tick starts a one-cycle blanking gap before the next position.
  - In the cycle after a tick: digit_en=0, blank=1, digit_out already holds the next digit.
  - In the following cycle, digit_en shows the new one-hot and blank=0.
  - Enabled time per slot is PRESCALE-1 cycles; slot period is unchanged.
  - Suppresses ghosting on shared segment lines.
- Not defined: blank is tied 0 and digit_en switches directly between positions.

## Test plan
- Reset/idle: NUM_DIGITS=4, PRESCALE=4, hold resetn=0, release → digit_en=0001, digit_out=0, load_ready=1; after 16 cycles digit_en has visited 0001,0010,0100,1000 and returned to 0001, each for 4 cycles.
- Frame load: offer load_data=16'hA5C3 at cycle 2 → load_ready=0 next cycle; after the next wrap, digit_out sequence is 3,C,5,A and load_ready=1 one cycle after the commit.
- Back-pressure: offer 16'h1234 while pfull=1 and hold valid → no transfer until load_ready=1; 16'h1234 then displayed one frame later, exactly once.
- Transfer on wrap tick: transfer 16'hFFFF in the same cycle as a wrap tick with pfull=0 → the coming frame still shows old disp; 16'hFFFF appears in the following frame.
- Mid-scan reset: pulse resetn low for half a cycle during idx=2 with a pending frame → outputs immediately at reset values; pending frame discarded; digits show 0.
- SCANNER_BLANK_EN defined, PRESCALE=4: each tick is followed by 1 cycle with digit_en=0000, blank=1, then 3 cycles of the one-hot enable.

Source files
------------

// File: rtl/hex_digit_scanner.sv
`default_nettype none
// ============================================================================
// Module   : hex_digit_scanner
// Purpose  : Time-multiplexed scanner for a row of 7-segment hex digits.
//            Holds one frame of NUM_DIGITS 4-bit digits and presents one
//            digit at a time to the segment decoders. A one-hot enable marks
//            the active position. New frames arrive through a valid/ready
//            handshake and are committed only at the frame boundary, so a
//            scan never shows a mix of two frames.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_DIGITS  number of display positions scanned (2..8)
//   PRESCALE    clock cycles per digit slot (>= 2)
// Ports
//   clock       in   rising-edge clock
//   resetn      in   asynchronous active-low reset
//   load_valid  in   upstream offers a frame on load_data
//   load_ready  out  scanner can accept a frame this cycle (registered)
//   load_data   in   frame, digit k in bits [4k+3:4k]
//   digit_out   out  current digit to the decoder (bit 3 -> c3 ... bit 0 -> c0)
//   digit_en    out  one-hot enable of the active position
//   blank       out  high while no position is enabled
// Build option
//   SCANNER_BLANK_EN  when defined, every slot change is preceded by a
//                     one-cycle gap with all positions disabled (blank=1).
//                     When undefined, blank is always 0.
// ============================================================================
module hex_digit_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [3:0]              digit_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    blank
);

    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int PCNT_W = $clog2(PRESCALE);

    localparam logic [PCNT_W-1:0]     c_pcnt_max = PCNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]      c_idx_last = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_en_pos0  = NUM_DIGITS'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PCNT_W-1:0]     r_pcnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_W-1:0]     r_disp;
    logic [DATA_W-1:0]     r_pend;
    logic                  r_pfull;
    logic                  r_load_ready;
    logic [3:0]            r_digit_out;
    logic [NUM_DIGITS-1:0] r_digit_en;
    logic                  r_blank;

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    logic                  w_tick;
    logic                  w_wrap;
    logic                  w_transfer;
    logic                  w_commit;
    logic                  w_pfull_next;
    logic [IDX_W-1:0]      w_next_idx;
    logic [DATA_W-1:0]     w_disp_eff;
    logic [DATA_W-1:0]     w_shifted;
    logic [3:0]            w_next_digit;
    logic [NUM_DIGITS-1:0] w_next_en;

    assign w_tick     = (r_pcnt == c_pcnt_max);
    assign w_wrap     = w_tick && (r_idx == c_idx_last);
    assign w_transfer = load_valid && r_load_ready;
    assign w_commit   = w_wrap && r_pfull;

    // Transfer needs pfull=0 and commit needs pfull=1, so the two never
    // coincide. A word transferred on a wrap tick lands in pend only and
    // waits for the next wrap; it is never bypassed into the display.
    assign w_pfull_next = w_transfer ? 1'b1 : (w_commit ? 1'b0 : r_pfull);

    assign w_next_idx = w_wrap ? '0 : r_idx + 1'b1;

    // The digit shown after a committing wrap tick comes from the frame
    // being committed, not from the outgoing display contents.
    assign w_disp_eff   = w_commit ? r_pend : r_disp;
    assign w_shifted    = w_disp_eff >> {w_next_idx, 2'b00};
    assign w_next_digit = w_shifted[3:0];
    assign w_next_en    = c_en_pos0 << w_next_idx;

`ifdef SCANNER_BLANK_EN
    // During the blanking gap r_idx already points at the new position.
    logic [NUM_DIGITS-1:0] w_idx_en;
    assign w_idx_en = c_en_pos0 << r_idx;
`endif

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pcnt       <= '0;
            r_idx        <= '0;
            r_disp       <= '0;
            r_pend       <= '0;
            r_pfull      <= 1'b0;
            r_load_ready <= 1'b1;
            r_digit_out  <= 4'h0;
            r_digit_en   <= c_en_pos0;
            r_blank      <= 1'b0;
        end else begin
            r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;

            if (w_tick) begin
                r_idx <= w_next_idx;
            end

            if (w_transfer) begin
                r_pend <= load_data;
            end

            if (w_commit) begin
                r_disp <= r_pend;
            end

            r_pfull      <= w_pfull_next;
            r_load_ready <= !w_pfull_next;

            if (w_tick) begin
                r_digit_out <= w_next_digit;
`ifdef SCANNER_BLANK_EN
                r_digit_en  <= '0;
                r_blank     <= 1'b1;
            end else if (r_blank) begin
                // PRESCALE >= 2 guarantees no tick lands inside the gap.
                r_digit_en  <= w_idx_en;
                r_blank     <= 1'b0;
`else
                r_digit_en  <= w_next_en;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign load_ready = r_load_ready;
    assign digit_out  = r_digit_out;
    assign digit_en   = r_digit_en;
    assign blank      = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_hex_digit_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_digit_scanner
// Purpose  : Directed self-checking bench for hex_digit_scanner with
//            NUM_DIGITS=4, PRESCALE=4. Expectations follow the edge count
//            since the last reset release; the enable pattern adapts to the
//            SCANNER_BLANK_EN build option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_digit_scanner;

    localparam int NUM_DIGITS = 4;
    localparam int PRESCALE   = 4;

    logic                    clock;
    logic                    resetn;
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_data;
    logic [3:0]              digit_out;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    blank;

    int total;
    int bad;
    int cyc;

    hex_digit_scanner #(
        .NUM_DIGITS (NUM_DIGITS),
        .PRESCALE   (PRESCALE)
    ) u_dut (
        .clock      (clock),
        .resetn     (resetn),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .digit_out  (digit_out),
        .digit_en   (digit_en),
        .blank      (blank)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // One rising edge, then sample 1 ns later.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) step();
    endtask

    // Expected enable n edges after reset release: ticks fall on multiples of 4.
    function automatic logic [31:0] exp_en(input int n);
        int idx;
        idx = (n / PRESCALE) % NUM_DIGITS;
`ifdef SCANNER_BLANK_EN
        if (n > 0 && (n % PRESCALE) == 0) return 32'd0;
`endif
        return 32'd1 << idx;
    endfunction

    function automatic logic [31:0] exp_blank(input int n);
`ifdef SCANNER_BLANK_EN
        if (n > 0 && (n % PRESCALE) == 0) return 32'd1;
`endif
        return 32'd0;
    endfunction

    initial begin
        total      = 0;
        bad        = 0;
        cyc        = 0;
        resetn     = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        chk("rst_en",    digit_en,   32'h1);
        chk("rst_digit", digit_out,  32'h0);
        chk("rst_ready", load_ready, 32'h1);
        chk("rst_blank", blank,      32'h0);

        // Idle scan: every position visited for 4 cycles, back to 0001
        resetn = 1'b1;
        cyc    = 0;
        for (int n = 1; n <= 16; n++) begin
            step();
            chk("scan_en",    digit_en,  exp_en(n));
            chk("scan_blank", blank,     exp_blank(n));
            chk("idle_digit", digit_out, 32'h0);
        end

        // Frame load: transfer at edge 17, commit at wrap edge 32
        load_valid = 1'b1;
        load_data  = 16'hA5C3;
        step();
        chk("load_ready_fall", load_ready, 32'h0);
        load_valid = 1'b0;
        load_data  = 16'h0000;
        go_to(31);
        chk("load_old_digit", digit_out, 32'h0);
        chk("load_ready_hold", load_ready, 32'h0);
        go_to(32);
        chk("load_d0", digit_out, 32'h3);
        chk("load_ready_rise", load_ready, 32'h1);
        chk("load_en0", digit_en, exp_en(32));
        go_to(36); chk("load_d1", digit_out, 32'hC);
        go_to(40); chk("load_d2", digit_out, 32'h5);
        go_to(44); chk("load_d3", digit_out, 32'hA);
        go_to(48); chk("load_again_d0", digit_out, 32'h3);

        // Back-pressure: 9876 fills pend, 1234 held until ready returns
        load_valid = 1'b1;
        load_data  = 16'h9876;
        step();
        chk("bp_ready0", load_ready, 32'h0);
        load_data = 16'h1234;
        go_to(63);
        chk("bp_blocked", load_ready, 32'h0);
        chk("bp_old_d3", digit_out, 32'hA);
        go_to(64);
        chk("bp_commit_d0", digit_out, 32'h6);
        chk("bp_ready1", load_ready, 32'h1);
        step();
        chk("bp_xfer", load_ready, 32'h0);
        load_valid = 1'b0;
        load_data  = 16'h0000;
        go_to(68); chk("bp_f1_d1", digit_out, 32'h7);
        go_to(72); chk("bp_f1_d2", digit_out, 32'h8);
        go_to(76); chk("bp_f1_d3", digit_out, 32'h9);
        go_to(80);
        chk("bp_f2_d0", digit_out, 32'h4);
        chk("bp_f2_ready", load_ready, 32'h1);
        go_to(84); chk("bp_f2_d1", digit_out, 32'h3);
        go_to(88); chk("bp_f2_d2", digit_out, 32'h2);
        go_to(92); chk("bp_f2_d3", digit_out, 32'h1);
        go_to(95); chk("bp_once_ready", load_ready, 32'h1);

        // Transfer on the wrap tick at edge 96: FFFF waits one more frame
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
        step();
        chk("wt_old_d0", digit_out, 32'h4);
        chk("wt_ready0", load_ready, 32'h0);
        load_valid = 1'b0;
        load_data  = 16'h0000;
        go_to(100); chk("wt_old_d1", digit_out, 32'h3);
        go_to(111);
        chk("wt_old_d3", digit_out, 32'h1);
        chk("wt_still_pend", load_ready, 32'h0);
        go_to(112);
        chk("wt_new_d0", digit_out, 32'hF);
        chk("wt_ready1", load_ready, 32'h1);
        go_to(116); chk("wt_new_d1", digit_out, 32'hF);

        // Mid-scan reset with 5555 pending
        load_valid = 1'b1;
        load_data  = 16'h5555;
        step();
        chk("mr_pend", load_ready, 32'h0);
        load_valid = 1'b0;
        load_data  = 16'h0000;
        go_to(121);
        chk("mr_idx2", digit_en, 32'h4);
        resetn = 1'b0;
        #1;
        chk("mr_en",    digit_en,   32'h1);
        chk("mr_digit", digit_out,  32'h0);
        chk("mr_ready", load_ready, 32'h1);
        chk("mr_blank", blank,      32'h0);
        #3;
        resetn = 1'b1;
        cyc    = 0;
        go_to(4);
        chk("mr_after_en", digit_en, exp_en(4));
        chk("mr_after_digit", digit_out, 32'h0);
        go_to(5);
        chk("mr_after_en5", digit_en, exp_en(5));
        go_to(16);
        chk("mr_wrap_digit", digit_out, 32'h0);
        chk("mr_wrap_ready", load_ready, 32'h1);
        chk("mr_wrap_en", digit_en, exp_en(16));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
